// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, scheduler state encoding and message byte helper
package uart_pkg;
    localparam logic [7:0] TERM_CHAR    = 8'h23;
    localparam int         CLKS_PER_BIT = 434;
    localparam int         MSG_MAX_LEN  = 15;

    typedef enum logic [2:0] {IDLE, SEND, WAIT, TERM, TERM_WAIT} tx_state_t;

    typedef logic [8*MSG_MAX_LEN-1:0] msg_bus_t;

    // Byte idx of a len-byte message packed with byte 0 in the most-significant position
    function automatic logic [7:0] msg_byte(input msg_bus_t msg, input int len, input int idx);
        return msg[8*(len-1-idx) +: 8];
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick of the first request after the last grant
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         sel
);
    // Scan from farthest to nearest so the nearest pending request after last wins
    always_comb begin
        sel = '0;
        for (int k = N; k >= 1; k--)
            if (req[(int'(last) + k) % N]) sel = N'(1) << ((int'(last) + k) % N);
    end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART serializer among message sources
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int         NUM_REQ   = 4,
    parameter int         MAX_LEN   = 14,
    parameter logic [7:0] TERM_CHAR = uart_pkg::TERM_CHAR
) (
    input  logic                       clk_50M,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*4-1:0]       req_len,
    input  logic [NUM_REQ*8*MAX_LEN-1:0] req_msg,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic                       busy,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_done
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int IW = $clog2(MAX_LEN);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int MW = 8 * MAX_LEN;

    tx_state_t       state, next_state;
    logic [NUM_REQ-1:0] sel;
    logic [GW-1:0]   sel_idx, gidx, last_grant;
    logic [LW-1:0]   sel_len, snap_len;
    logic [IW-1:0]   index;
    logic [MW-1:0]   snap_msg;
    logic            last_byte;

    rr_arbiter #(.N(NUM_REQ)) u_arb (.req(req), .last(last_grant), .sel(sel));

    assign busy      = state != IDLE;
    assign last_byte = LW'(index) == snap_len - LW'(1);

    // Encode the selected source and clamp its length to the payload capacity
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) if (sel[i]) sel_idx = GW'(i);
        sel_len = int'(req_len[4*sel_idx +: 4]) > MAX_LEN ? LW'(MAX_LEN) : LW'(req_len[4*sel_idx +: 4]);
    end

    // State register
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next state; tx_done outside WAIT/TERM_WAIT is ignored
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      next_state = |req ? (sel_len == '0 ? TERM : SEND) : IDLE;
            SEND:      next_state = WAIT;
            WAIT:      next_state = tx_done ? (last_byte ? TERM : SEND) : WAIT;
            TERM:      next_state = TERM_WAIT;
            TERM_WAIT: next_state = tx_done ? IDLE : TERM_WAIT;
            default:   next_state = IDLE;
        endcase
    end

    // Grant, snapshot, byte index and serializer handshake registers
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            grant      <= '0;
            done       <= '0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            last_grant <= GW'(NUM_REQ - 1);
            gidx       <= '0;
            snap_len   <= '0;
            snap_msg   <= '0;
            index      <= '0;
        end else begin
            done     <= '0;
            tx_start <= state == SEND || state == TERM;
            case (state)
                IDLE: if (|req) begin
                    grant    <= sel;
                    gidx     <= sel_idx;
                    snap_len <= sel_len;
                    snap_msg <= req_msg[MW*sel_idx +: MW];
                    index    <= '0;
                end
                SEND: tx_data <= msg_byte(msg_bus_t'(snap_msg), MAX_LEN, int'(index));
                WAIT: if (tx_done && !last_byte) index <= index + 1'b1;
                TERM: tx_data <= TERM_CHAR;
                TERM_WAIT: if (tx_done) begin
                    done       <= grant;
                    grant      <= '0;
                    last_grant <= gidx;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: randomized scoreboard bench with a message-level reference model
module tb_uart_tx_scheduler;
    logic         clk_50M = 0;
    logic         rst;
    logic [3:0]   req;
    logic [15:0]  req_len;
    logic [447:0] req_msg;
    logic [3:0]   grant, done;
    logic         busy, tx_start, tx_done;
    logic [7:0]   tx_data;

    uart_tx_scheduler dut (
        .clk_50M(clk_50M), .rst(rst), .req(req), .req_len(req_len), .req_msg(req_msg),
        .grant(grant), .done(done), .busy(busy), .tx_start(tx_start), .tx_data(tx_data),
        .tx_done(tx_done)
    );

    always #10 clk_50M = ~clk_50M;

    int n_cmp = 0, n_err = 0;
    int exp_grant[$], exp_done[$];
    logic [7:0] exp_bytes[$];
    logic [111:0] msg_tab[4][4];
    int len_tab[4][4];
    int cnt[4], sent[4];
    int m_last = 3;
    int lat = 3;
    int n_start = 0, n_done = 0;
    logic spur = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name, input int act, input int exp);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [111:0] rnd112();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[111:0];
    endfunction

    task automatic gen(input logic [15:0] cnts);
        for (int s = 0; s < 4; s++) begin
            cnt[s]  = int'(cnts[4*s +: 4]);
            sent[s] = 0;
            for (int k = 0; k < 4; k++) begin
                len_tab[s][k] = $urandom_range(0, 15);
                msg_tab[s][k] = rnd112();
            end
        end
    endtask

    // Reference: rotate from the last served source, clamp length, append terminator
    task automatic plan();
        int rem[4];
        int tot, s, kk, l;
        logic [111:0] m;
        tot = 0;
        for (int i = 0; i < 4; i++) begin rem[i] = cnt[i]; tot += cnt[i]; end
        while (tot > 0) begin
            s = -1;
            for (int k = 1; k <= 4 && s < 0; k++)
                if (rem[(m_last + k) % 4] > 0) s = (m_last + k) % 4;
            kk = cnt[s] - rem[s];
            rem[s]--;
            tot--;
            m_last = s;
            exp_grant.push_back(s);
            exp_done.push_back(s);
            l = len_tab[s][kk] > 14 ? 14 : len_tab[s][kk];
            m = msg_tab[s][kk];
            for (int b = 0; b < l; b++) exp_bytes.push_back(m[111-8*b -: 8]);
            exp_bytes.push_back(8'h23);
        end
        for (int i = 0; i < 4; i++)
            if (cnt[i] > 0) begin
                req_msg[112*i +: 112] = msg_tab[i][0];
                req_len[4*i +: 4]     = 4'(len_tab[i][0]);
            end
    endtask

    task automatic go();
        for (int s = 0; s < 4; s++) req[s] = cnt[s] > 0;
    endtask

    task automatic wait_idle(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(negedge clk_50M);
            if (exp_grant.size() == 0 && exp_bytes.size() == 0 && exp_done.size() == 0 && !busy && req == 0) break;
        end
        if (i == bound) bad("idle timeout, bytes left", exp_bytes.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk_50M);
        rst = 1;
        req = '0;
        repeat (3) @(negedge clk_50M);
        rst = 0;
        m_last = 3;
    endtask

    // Serializer model: one-cycle tx_done lat cycles after each start
    initial begin
        int c;
        c = 0;
        tx_done = 0;
        forever begin
            @(negedge clk_50M);
            tx_done = 0;
            if (rst) c = 0;
            else begin
                if (c > 0) begin c--; if (c == 0) tx_done = 1; end
                if (spur) begin tx_done = 1; spur = 0; end
                if (tx_start) c = lat;
            end
        end
    end

    // Source driver: on each grant load the next message or drop req and scramble the buffer
    initial begin
        logic [3:0] prev;
        prev = '0;
        forever begin
            @(negedge clk_50M);
            if (grant != 0 && prev == 0)
                for (int s = 0; s < 4; s++)
                    if (grant[s]) begin
                        sent[s]++;
                        if (sent[s] >= cnt[s]) begin
                            req[s] = 0;
                            req_msg[112*s +: 112] = rnd112();
                            req_len[4*s +: 4]     = 4'($urandom);
                        end else begin
                            req_msg[112*s +: 112] = msg_tab[s][sent[s]];
                            req_len[4*s +: 4]     = 4'(len_tab[s][sent[s]]);
                        end
                    end
            prev = grant;
        end
    end

    // Monitor: compare every grant, byte and done against the scoreboard queues
    initial begin
        logic [3:0] prev;
        logic rose, td;
        prev = '0;
        rose = 0;
        td   = 0;
        forever begin
            @(posedge clk_50M);
            #1;
            if (rose) chk("tx_start one cycle after grant", tx_start, 1);
            if (td && prev != 0 && grant != 0) chk("tx_start one cycle after tx_done", tx_start, 1);
            if (tx_start) begin
                n_start++;
                if (exp_bytes.size() == 0) bad("unexpected tx_start, queued bytes", 0, 1);
                else chk("tx_data", tx_data, exp_bytes.pop_front());
            end
            rose = grant != 0 && prev == 0;
            if (rose) begin
                if (exp_grant.size() == 0) bad("unexpected grant, queued grants", 0, 1);
                else chk("grant", grant, 32'(1) << exp_grant.pop_front());
                chk("busy with grant", busy, 1);
            end
            if (done != 0) begin
                n_done++;
                if (exp_done.size() == 0) bad("unexpected done, queued dones", 0, 1);
                else chk("done", done, 32'(1) << exp_done.pop_front());
                chk("grant cleared with done", grant, 0);
                chk("busy cleared with done", busy, 0);
            end
            td   = tx_done;
            prev = grant;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, d0;
        logic [15:0] c;
        rst = 1;
        req = '0;
        req_len = '0;
        req_msg = '0;
        gen(16'h1111);
        plan();
        go();
        repeat (5) begin
            @(negedge clk_50M);
            chk("grant in reset", grant, 0);
            chk("tx_start in reset", tx_start, 0);
            chk("busy in reset", busy, 0);
        end
        chk("tx_data in reset", tx_data, 0);
        rst = 0;
        @(posedge clk_50M);
        #1;
        chk("grant after reset release", grant, 4'b0001);
        wait_idle(5000);

        spur = 1;
        repeat (4) @(negedge clk_50M);
        chk("busy after idle tx_done", busy, 0);
        chk("grant after idle tx_done", grant, 0);

        lat = 4340;
        gen(16'h0010);
        len_tab[1][0] = 3;
        msg_tab[1][0] = {24'h414243, 88'h0};
        s0 = n_start;
        d0 = n_done;
        plan();
        go();
        wait_idle(25000);
        chk("ABC tx_start count", n_start - s0, 4);
        chk("ABC done count", n_done - d0, 1);
        lat = 3;

        do_reset();
        gen(16'h0102);
        plan();
        go();
        wait_idle(5000);

        do_reset();
        gen(16'h2222);
        plan();
        go();
        wait_idle(8000);

        do_reset();
        gen(16'h1001);
        len_tab[0][0] = 0;
        len_tab[3][0] = 15;
        s0 = n_start;
        plan();
        go();
        wait_idle(5000);
        chk("len 0 + len 15 tx_start count", n_start - s0, 16);

        repeat (6) begin
            lat = $urandom_range(1, 6);
            for (int s = 0; s < 4; s++) c[4*s +: 4] = 4'($urandom_range(0, 2));
            if (c == 0) c = 16'h0001;
            gen(c);
            plan();
            go();
            wait_idle(8000);
        end

        do_reset();
        gen(16'h0100);
        len_tab[2][0] = 5;
        s0 = n_start;
        plan();
        go();
        for (int i = 0; i < 2000 && n_start < s0 + 2; i++) @(negedge clk_50M);
        if (n_start < s0 + 2) bad("starts before mid-message reset", n_start - s0, 2);
        @(negedge clk_50M);
        rst = 1;
        #1;
        chk("grant on mid reset", grant, 0);
        chk("busy on mid reset", busy, 0);
        chk("tx_start on mid reset", tx_start, 0);
        chk("tx_data on mid reset", tx_data, 0);
        chk("done on mid reset", done, 0);
        exp_bytes.delete();
        exp_grant.delete();
        exp_done.delete();
        d0 = n_done;
        req = '0;
        repeat (3) @(negedge clk_50M);
        rst = 0;
        m_last = 3;
        gen(16'h1000);
        len_tab[3][0] = 4;
        plan();
        go();
        wait_idle(5000);
        chk("done count after mid reset", n_done - d0, 1);

        repeat (3) @(negedge clk_50M);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
